// File: rtl/time_stamp_packer.sv
// Frames a triggered ADC sample stream as header / payload / footer AXI-Stream words,
// stamping trigger and end times plus the timer wrap count into header and footer.
module time_stamp_packer #(
    parameter int TIME_STAMP_WIDTH = 16,
    parameter int WRAP_WIDTH       = 8,
    parameter int MAX_SAMPLES      = 64
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESET,
    input  logic [1:0]                  EXEC_STATE,
    input  logic [TIME_STAMP_WIDTH-1:0] I_CURRENT_TIME,
    input  logic [15:0]                 S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    output logic                        S_AXIS_TREADY,
    output logic [31:0]                 M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic                        M_AXIS_TLAST,
    output logic [WRAP_WIDTH-1:0]       O_WRAP_COUNT,
    output logic [7:0]                  O_DROP_COUNT
);

    localparam logic [1:0] EXEC_INIT = 2'b00;
    localparam logic [1:0] EXEC_TRG  = 2'b11;
    localparam logic [7:0] TAG_HDR   = 8'hAA;
    localparam logic [7:0] TAG_PLD   = 8'h55;
    localparam logic [7:0] TAG_FTR   = 8'hFF;
    localparam logic [7:0] MAX_CNT   = 8'(MAX_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_FOOTER
    } state_t;

    state_t                        state_reg;
    logic [1:0]                    prev_state_reg;
    logic [TIME_STAMP_WIDTH-1:0]   prev_time_reg;
    logic                          trig_armed_reg;
    logic [WRAP_WIDTH-1:0]         wrap_reg;
    logic [7:0]                    drop_reg;
    logic [7:0]                    sample_cnt_reg;
    logic                          closed_reg;
    logic [15:0]                   end_time_reg;
    logic [31:0]                   m_data_reg;
    logic                          m_valid_reg;
    logic                          m_last_reg;

    logic        trig_edge;
    logic        trig_end;
    logic        wrap_hit;
    logic        out_free;
    logic        close_now;
    logic        s_ready;
    logic        s_accept;
    logic [15:0] time16;
    logic [7:0]  wrap8;

    // Header always carries an 8-bit wrap field, zero-extended for narrow counters.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wrap8
            if (gi < WRAP_WIDTH) begin : g_bit
                assign wrap8[gi] = wrap_reg[gi];
            end else begin : g_pad
                assign wrap8[gi] = 1'b0;
            end
        end
    endgenerate

    assign time16 = I_CURRENT_TIME[15:0];

    // trig_armed_reg stops a TRG level present at reset release from counting as an edge.
    assign trig_edge = trig_armed_reg && (EXEC_STATE == EXEC_TRG) && (prev_state_reg != EXEC_TRG);
    assign trig_end  = (EXEC_STATE != EXEC_TRG);
    assign wrap_hit  = (EXEC_STATE != EXEC_INIT) && (prev_state_reg != EXEC_INIT)
                       && (I_CURRENT_TIME < prev_time_reg);

    assign out_free  = !m_valid_reg || M_AXIS_TREADY;
    assign close_now = trig_end || (sample_cnt_reg == MAX_CNT);
    assign s_ready   = (state_reg == S_PAYLOAD) && !close_now && out_free;
    assign s_accept  = s_ready && S_AXIS_TVALID;

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TDATA  = m_data_reg;
    assign M_AXIS_TVALID = m_valid_reg;
    assign M_AXIS_TLAST  = m_last_reg;
    assign O_WRAP_COUNT  = wrap_reg;
    assign O_DROP_COUNT  = drop_reg;

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_reg      <= S_IDLE;
            prev_state_reg <= EXEC_INIT;
            prev_time_reg  <= '0;
            trig_armed_reg <= 1'b0;
            wrap_reg       <= '0;
            drop_reg       <= 8'h00;
            sample_cnt_reg <= 8'h00;
            closed_reg     <= 1'b0;
            end_time_reg   <= 16'h0000;
            m_data_reg     <= 32'h0000_0000;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
        end else begin
            prev_state_reg <= EXEC_STATE;
            prev_time_reg  <= I_CURRENT_TIME;
            if (EXEC_STATE != EXEC_TRG) begin
                trig_armed_reg <= 1'b1;
            end

            if (EXEC_STATE == EXEC_INIT) begin
                wrap_reg <= '0;
            end else if (wrap_hit) begin
                wrap_reg <= wrap_reg + 1'b1;
            end

            if (trig_edge && (state_reg != S_IDLE) && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (trig_edge) begin
                        m_data_reg     <= {TAG_HDR, wrap8, time16};
                        m_valid_reg    <= 1'b1;
                        m_last_reg     <= 1'b0;
                        sample_cnt_reg <= 8'h00;
                        closed_reg     <= 1'b0;
                        state_reg      <= S_HEADER;
                    end
                end

                S_HEADER: begin
                    // The header is already latched, so an early end only queues the footer.
                    if (trig_end && !closed_reg) begin
                        closed_reg   <= 1'b1;
                        end_time_reg <= time16;
                    end
                    if (M_AXIS_TREADY) begin
                        if (closed_reg || trig_end) begin
                            m_data_reg <= {TAG_FTR, sample_cnt_reg,
                                           closed_reg ? end_time_reg : time16};
                            m_last_reg <= 1'b1;
                            state_reg  <= S_FOOTER;
                        end else begin
                            m_valid_reg <= 1'b0;
                            state_reg   <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (close_now) begin
                        end_time_reg <= time16;
                        state_reg    <= S_FOOTER;
                        if (out_free) begin
                            m_data_reg  <= {TAG_FTR, sample_cnt_reg, time16};
                            m_valid_reg <= 1'b1;
                            m_last_reg  <= 1'b1;
                        end
                    end else if (s_accept) begin
                        m_data_reg     <= {TAG_PLD, 8'h00, S_AXIS_TDATA};
                        m_valid_reg    <= 1'b1;
                        sample_cnt_reg <= sample_cnt_reg + 8'd1;
                    end else if (M_AXIS_TREADY) begin
                        m_valid_reg <= 1'b0;
                    end
                end

                S_FOOTER: begin
                    if (m_last_reg) begin
                        if (M_AXIS_TREADY) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            state_reg   <= S_IDLE;
                        end
                    end else if (out_free) begin
                        // The last payload word has drained; present the footer now.
                        m_data_reg  <= {TAG_FTR, sample_cnt_reg, end_time_reg};
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_stamp_packer.sv
// Directed bench for time_stamp_packer: frames, wrap count, backpressure, max length,
// drop counting and asynchronous reset.
module tb_time_stamp_packer;

    logic        AXIS_ACLK;
    logic        AXIS_ARESET;
    logic [1:0]  EXEC_STATE;
    logic [15:0] I_CURRENT_TIME;
    logic [15:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic [7:0]  O_WRAP_COUNT;
    logic [7:0]  O_DROP_COUNT;

    time_stamp_packer #(
        .TIME_STAMP_WIDTH(16),
        .WRAP_WIDTH      (8),
        .MAX_SAMPLES     (4)
    ) dut (
        .AXIS_ACLK     (AXIS_ACLK),
        .AXIS_ARESET   (AXIS_ARESET),
        .EXEC_STATE    (EXEC_STATE),
        .I_CURRENT_TIME(I_CURRENT_TIME),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .O_WRAP_COUNT  (O_WRAP_COUNT),
        .O_DROP_COUNT  (O_DROP_COUNT)
    );

    initial begin
        AXIS_ACLK = 1'b0;
        forever #5 AXIS_ACLK = ~AXIS_ACLK;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          src_left = 0;
    logic [32:0] mon_q[$];
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes at the falling edge, then advance the sample source.
    task automatic step();
        logic s_acc;
        @(negedge AXIS_ACLK);
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            mon_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
            $display("[TB] t=%0t word %h last=%0b", $time, M_AXIS_TDATA, M_AXIS_TLAST);
        end
        s_acc = S_AXIS_TVALID && S_AXIS_TREADY;
        @(posedge AXIS_ACLK);
        #1;
        if (s_acc) begin
            src_left--;
            if (src_left == 0) S_AXIS_TVALID = 1'b0;
            else S_AXIS_TDATA = S_AXIS_TDATA + 16'd1;
        end
    endtask

    task automatic start_src(input logic [15:0] base, input int n);
        S_AXIS_TDATA  = base;
        src_left      = n;
        S_AXIS_TVALID = (n > 0);
    endtask

    task automatic ex(input logic last, input logic [31:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic run_until_last(input string tag, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            if (mon_q.size() > 0 && mon_q[mon_q.size()-1][32]) seen = 1'b1;
        end
        chk({tag, "_footer_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_len"}, 64'(mon_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mon_q.size())
                chk($sformatf("%s_w%0d", tag, i), 64'(mon_q[i]), 64'(exp_q[i]));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        AXIS_ARESET    = 1'b1;
        EXEC_STATE     = 2'b00;
        I_CURRENT_TIME = 16'h0001;
        S_AXIS_TDATA   = 16'h0000;
        S_AXIS_TVALID  = 1'b0;
        M_AXIS_TREADY  = 1'b1;
        repeat (3) step();

        chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("rst_tlast",  64'(M_AXIS_TLAST),  64'd0);
        chk("rst_tdata",  64'(M_AXIS_TDATA),  64'd0);
        chk("rst_sready", 64'(S_AXIS_TREADY), 64'd0);
        chk("rst_wrap",   64'(O_WRAP_COUNT),  64'd0);
        chk("rst_drop",   64'(O_DROP_COUNT),  64'd0);
        AXIS_ARESET = 1'b0;
        repeat (2) step();

        // Basic frame: three samples, end at time 0x0020.
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0010;
        start_src(16'h0001, 3);
        for (int i = 0; i < 20 && S_AXIS_TVALID; i++) step();
        EXEC_STATE = 2'b01; I_CURRENT_TIME = 16'h0020;
        run_until_last("basic", 20);
        ex(0, 32'hAA000010); ex(0, 32'h55000001); ex(0, 32'h55000002);
        ex(0, 32'h55000003); ex(1, 32'hFF030020);
        chk_frame("basic");

        // Two timer wraps outside INIT, then a trigger ended early by INIT.
        I_CURRENT_TIME = 16'hFFFE; step();
        I_CURRENT_TIME = 16'hFFFF; step();
        I_CURRENT_TIME = 16'h0001; step();
        I_CURRENT_TIME = 16'h0002; step();
        I_CURRENT_TIME = 16'hFFFF; step();
        I_CURRENT_TIME = 16'h0001; step();
        I_CURRENT_TIME = 16'h0003; step();
        chk("wrap_count2", 64'(O_WRAP_COUNT), 64'd2);
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0005; step();
        EXEC_STATE = 2'b00; I_CURRENT_TIME = 16'h0001; step();
        chk("wrap_clear", 64'(O_WRAP_COUNT), 64'd0);
        run_until_last("wrap", 10);
        ex(0, 32'hAA020005); ex(1, 32'hFF000001);
        chk_frame("wrap");

        // Backpressure on the first payload word for five cycles.
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0100;
        start_src(16'h00A1, 3);
        repeat (3) step();
        chk("bp_first_word", 64'(M_AXIS_TDATA), 64'h550000A1);
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_tdata_c%0d", i),  64'(M_AXIS_TDATA),  64'h550000A1);
            chk($sformatf("bp_tvalid_c%0d", i), 64'(M_AXIS_TVALID), 64'd1);
            chk($sformatf("bp_sready_c%0d", i), 64'(S_AXIS_TREADY), 64'd0);
        end
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 20 && S_AXIS_TVALID; i++) step();
        EXEC_STATE = 2'b01; I_CURRENT_TIME = 16'h0200;
        run_until_last("bp", 20);
        ex(0, 32'hAA000100); ex(0, 32'h550000A1); ex(0, 32'h550000A2);
        ex(0, 32'h550000A3); ex(1, 32'hFF030200);
        chk_frame("bp");

        // Max length: continuous stream, TRG held, closes after four samples.
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0300;
        start_src(16'h00B1, 9);
        repeat (14) step();
        chk("max_sready_idle", 64'(S_AXIS_TREADY), 64'd0);
        chk("max_tvalid_idle", 64'(M_AXIS_TVALID), 64'd0);
        ex(0, 32'hAA000300); ex(0, 32'h550000B1); ex(0, 32'h550000B2);
        ex(0, 32'h550000B3); ex(0, 32'h550000B4); ex(1, 32'hFF040300);
        chk_frame("max");
        start_src(16'h0000, 0);

        // Second trigger edge while the frame is still draining is dropped.
        EXEC_STATE = 2'b01; step();
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0400;
        start_src(16'h00C1, 2);
        repeat (4) step();
        M_AXIS_TREADY = 1'b0;
        EXEC_STATE = 2'b01; I_CURRENT_TIME = 16'h0410; step();
        EXEC_STATE = 2'b11; step();
        chk("drop_one", 64'(O_DROP_COUNT), 64'd1);
        M_AXIS_TREADY = 1'b1;
        repeat (8) step();
        ex(0, 32'hAA000400); ex(0, 32'h550000C1); ex(0, 32'h550000C2);
        ex(1, 32'hFF020410);
        chk_frame("drop");

        // Hold a header under backpressure and toggle the trigger 300 times.
        EXEC_STATE = 2'b01; step();
        M_AXIS_TREADY = 1'b0;
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0500; step();
        for (int i = 0; i < 10; i++) begin
            EXEC_STATE = 2'b01; step();
            EXEC_STATE = 2'b11; step();
        end
        chk("drop_eleven", 64'(O_DROP_COUNT), 64'd11);
        for (int i = 0; i < 290; i++) begin
            EXEC_STATE = 2'b01; step();
            EXEC_STATE = 2'b11; step();
        end
        chk("drop_saturate", 64'(O_DROP_COUNT), 64'hFF);
        chk("hold_tdata",  64'(M_AXIS_TDATA),  64'hAA000500);
        chk("hold_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        chk("hold_tlast",  64'(M_AXIS_TLAST),  64'd0);
        M_AXIS_TREADY = 1'b1;
        run_until_last("hold", 10);
        ex(0, 32'hAA000500); ex(1, 32'hFF000500);
        chk_frame("hold");

        // Asynchronous reset between clock edges in the middle of a payload.
        EXEC_STATE = 2'b01; step();
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0600;
        start_src(16'h00D1, 10);
        repeat (4) step();
        chk("pre_rst_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        #2;
        AXIS_ARESET = 1'b1;
        #1;
        chk("arst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("arst_tdata",  64'(M_AXIS_TDATA),  64'd0);
        chk("arst_tlast",  64'(M_AXIS_TLAST),  64'd0);
        chk("arst_sready", 64'(S_AXIS_TREADY), 64'd0);
        chk("arst_wrap",   64'(O_WRAP_COUNT),  64'd0);
        chk("arst_drop",   64'(O_DROP_COUNT),  64'd0);
        mon_q.delete();
        step();
        AXIS_ARESET = 1'b0;
        repeat (10) step();
        chk("post_rst_words",  64'(mon_q.size()),   64'd0);
        chk("post_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        mon_q.delete();

        // A fresh edge after release still produces a frame.
        EXEC_STATE = 2'b01; step();
        EXEC_STATE = 2'b11; I_CURRENT_TIME = 16'h0700;
        start_src(16'h0000, 0);
        step();
        EXEC_STATE = 2'b01; I_CURRENT_TIME = 16'h0701;
        run_until_last("after_rst", 10);
        ex(0, 32'hAA000700); ex(1, 32'hFF000701);
        chk_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_stamp_packer.md
TIME_STAMP_PACKER -- requirements
Module: time_stamp_packer

Interface
REQ-001 SHALL have parameter TIME_STAMP_WIDTH, default 16, the width of I_CURRENT_TIME; only 16 is supported.
REQ-002 SHALL have parameter WRAP_WIDTH, default 8, the width of the timestamp wrap counter.
REQ-003 SHALL have parameter MAX_SAMPLES, default 64, the maximum number of payload words per frame; legal range 1..255.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port AXIS_ACLK, input, 1 bit: the sole clock, rising edge.
REQ-006 SHALL have port AXIS_ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port EXEC_STATE, input, 2 bits: run state; INIT=2'b00, TRG=2'b11.
REQ-008 SHALL have port I_CURRENT_TIME, input, TIME_STAMP_WIDTH bits: timer value, which counts 1..2^W-1 then wraps to 1, and is held at 1 during INIT.
REQ-009 SHALL have port S_AXIS_TDATA, input, 16 bits: ADC sample.
REQ-010 SHALL have port S_AXIS_TVALID, input, 1 bit: sample valid.
REQ-011 SHALL have port S_AXIS_TREADY, output, 1 bit: sample accepted.
REQ-012 SHALL have port M_AXIS_TDATA, output, 32 bits: frame word.
REQ-013 SHALL have ports M_AXIS_TVALID (output), M_AXIS_TREADY (input) and M_AXIS_TLAST (output), each 1 bit: the frame handshake.
REQ-014 SHALL have port O_WRAP_COUNT, output, WRAP_WIDTH bits: number of timer wraps seen.
REQ-015 SHALL have port O_DROP_COUNT, output, 8 bits: number of triggers lost while a frame was busy.

Function
REQ-016 SHALL register EXEC_STATE and I_CURRENT_TIME each cycle as prev_state and prev_time.
REQ-017 SHALL define trig_edge = (EXEC_STATE==TRG) && (prev_state!=TRG).
REQ-018 SHALL define trig_end = (EXEC_STATE!=TRG).
REQ-019 Wrap detect: SHALL increment O_WRAP_COUNT (modulo 2^WRAP_WIDTH) when EXEC_STATE!=INIT, prev_state!=INIT and I_CURRENT_TIME < prev_time.
REQ-020 SHALL clear O_WRAP_COUNT to 0 in any cycle where EXEC_STATE==INIT.
REQ-021 SHALL implement an FSM with states IDLE, HEADER, PAYLOAD and FOOTER.
REQ-022 IDLE->HEADER on trig_edge: SHALL capture I_CURRENT_TIME and O_WRAP_COUNT[7:0] from the edge cycle; the header SHALL present M_AXIS_TVALID=1 on the next cycle.
REQ-023 Header word SHALL be {8'hAA, wrap[7:0], timestamp[15:0]} with M_AXIS_TLAST=0; the FSM SHALL move to PAYLOAD when the header is accepted (TVALID&&TREADY).
REQ-024 In PAYLOAD: S_AXIS_TREADY SHALL be 1 when (!M_AXIS_TVALID || M_AXIS_TREADY) and the frame has not closed, otherwise 0.
REQ-025 Each accepted sample SHALL be loaded as {8'h55, 8'h00, sample} and SHALL increment sample_cnt (8 bits, cleared at HEADER entry).
REQ-026 PAYLOAD->FOOTER on trig_end or when sample_cnt==MAX_SAMPLES, whichever occurs first: SHALL capture I_CURRENT_TIME of that cycle as end time, and S_AXIS_TREADY SHALL be 0 from that cycle.
REQ-027 Any pending payload word SHALL complete before the footer is presented.
REQ-028 Footer word SHALL be {8'hFF, sample_cnt[7:0], end_time[15:0]} with M_AXIS_TLAST=1; on footer acceptance the FSM SHALL go to IDLE.
REQ-029 Zero-sample frames SHALL be legal: trig_end before any sample is accepted yields header then footer with count 0.
REQ-030 If trig_end occurs while in HEADER, the header SHALL still be sent, followed immediately by a footer.
REQ-031 EXEC_STATE==INIT mid-frame SHALL be treated as trig_end; the wrap clear SHALL not alter the already-captured header fields.
REQ-032 trig_edge while the FSM is not in IDLE SHALL increment O_DROP_COUNT, saturating at 8'hFF, and SHALL not start a frame.
REQ-033 After a MAX_SAMPLES close, a new frame SHALL require EXEC_STATE to leave TRG and then re-enter it.
REQ-034 M_AXIS_TDATA, M_AXIS_TVALID and M_AXIS_TLAST SHALL be registered and SHALL hold stable while TVALID=1 and TREADY=0.
REQ-035 TVALID SHALL never drop without a handshake.
REQ-036 Throughput SHALL be one word per cycle when M_AXIS_TREADY=1 and S_AXIS_TVALID=1.

Reset
REQ-037 On AXIS_ARESET=1, without waiting for a clock edge, SHALL force: FSM=IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, O_WRAP_COUNT=0, O_DROP_COUNT=0, sample_cnt=0, prev_state=INIT, prev_time=0.
REQ-038 A reset mid-frame SHALL discard the frame; no footer SHALL be emitted after release.
REQ-039 After release the first trig_edge SHALL require EXEC_STATE to be sampled as non-TRG then TRG.

Verification
REQ-040 Basic frame: EXEC_STATE 00->11 with I_CURRENT_TIME=0x0010, 3 samples 0x0001..0x0003, TREADY=1, then EXEC_STATE->01 at time 0x0020 -> words 0xAA000010, 0x55000001, 0x55000002, 0x55000003, 0xFF030020 (TLAST on the last word only).
REQ-041 Wrap: I_CURRENT_TIME steps 0xFFFF->0x0001 twice with EXEC_STATE=01, then a trigger at time 0x0005 -> O_WRAP_COUNT=2 and header=0xAA020005; EXEC_STATE=00 afterwards -> O_WRAP_COUNT=0.
REQ-042 Backpressure: TREADY held 0 for 5 cycles during payload -> TDATA/TVALID stable, S_AXIS_TREADY=0, no sample lost or duplicated.
REQ-043 Max length: MAX_SAMPLES=4 with a continuous sample stream and EXEC_STATE held at 11 -> 4 payload words, footer count 0x04, no second frame until EXEC_STATE toggles.
REQ-044 Drop: a second 01->11 edge while in PAYLOAD -> O_DROP_COUNT=1 and the current frame is unaffected; repeat 300 drops -> saturates at 0xFF.
REQ-045 Async reset: assert AXIS_ARESET between clock edges mid-payload -> M_AXIS_TVALID=0 immediately, all counters 0, and no footer after release.
